// File: rtl/scfifo_burst_reader.sv
// scfifo_burst_reader
// Drains a show-ahead single-clock FIFO and emits its words as a valid/ready
// stream framed into bursts of up to BURST_MAX words. A partial burst is
// released once it has waited TIMEOUT cycles in the coalescing state.
//
// Optional feature macro: SCFIFO_BURST_READER_STATS_EN
//   defined   -> o_bursts / o_timeouts are live 32-bit wrapping counters
//   undefined -> both outputs are tied to zero
//
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   fifo_rval        FIFO head word valid (show-ahead)
//   fifo_rdat        FIFO head word
//   fifo_used        FIFO occupancy, signed; <= 0 means empty
//   fifo_rden        pop the FIFO head this cycle (combinational)
//   m_valid/m_data   stream word, driven from the skid head register
//   m_last           final word of the burst
//   m_ready          sink accepts the current word
//   o_bursts         bursts completed (last word accepted)
//   o_timeouts       bursts released by timeout
module scfifo_burst_reader #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 6,
    parameter int BURST_MAX = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   fifo_rval,
    input  logic [DATA_BITS-1:0]   fifo_rdat,
    input  logic signed [ADDR_BITS:0] fifo_used,
    output logic                   fifo_rden,
    output logic                   m_valid,
    output logic [DATA_BITS-1:0]   m_data,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic [31:0]            o_bursts,
    output logic [31:0]            o_timeouts
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic signed [ADDR_BITS:0] C_BMAX = (ADDR_BITS + 1)'(BURST_MAX);
    localparam logic signed [ADDR_BITS:0] C_ONE  = (ADDR_BITS + 1)'(1);
    localparam logic signed [ADDR_BITS:0] C_ZERO = '0;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] C_TMR_MAX  = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COALESCE,
        S_BURST
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic [CNT_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;
    logic               w_rden;
    logic               w_pop_last;

    logic [1:0]           r_skid_cnt;
    logic [DATA_BITS-1:0] r_head_d, r_tail_d;
    logic                 r_head_l, r_tail_l;
    logic                 w_skid_pop;

    // Word being popped closes the burst when it fills it or empties the FIFO.
    assign w_pop_last = (r_burst_cnt == C_CNT_LAST) || (fifo_used == C_ONE);

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_burst_cnt_nxt = r_burst_cnt;
        // Gated by srst so nothing is popped while reset is held mid-burst.
        w_rden = !srst && (r_state == S_BURST) && fifo_rval && (r_skid_cnt < 2'd2);
        case (r_state)
            S_IDLE: begin
                if (fifo_used >= C_BMAX) begin
                    w_state_nxt = S_BURST;
                end else if (fifo_used > C_ZERO) begin
                    w_state_nxt = S_COALESCE;
                    w_timer_nxt = '0;
                end
            end
            S_COALESCE: begin
                if (fifo_used <= C_ZERO) begin
                    w_state_nxt = S_IDLE;
                end else if (fifo_used >= C_BMAX || r_timer == C_TMR_LAST) begin
                    w_state_nxt = S_BURST;
                end else if (r_timer != C_TMR_MAX) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_BURST: begin
                if (w_rden) begin
                    if (w_pop_last) begin
                        w_burst_cnt_nxt = '0;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    assign fifo_rden  = w_rden;
    assign w_skid_pop = (r_skid_cnt != 2'd0) && m_ready;

    // Two-entry skid: outputs come only from the head register, so m_ready
    // never reaches the stream outputs combinationally.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_skid_cnt <= '0;
            r_head_d   <= '0;
            r_head_l   <= 1'b0;
            r_tail_d   <= '0;
            r_tail_l   <= 1'b0;
        end else begin
            case ({w_rden, w_skid_pop})
                2'b10: begin
                    if (r_skid_cnt == 2'd0) begin
                        r_head_d <= fifo_rdat;
                        r_head_l <= w_pop_last;
                    end else begin
                        r_tail_d <= fifo_rdat;
                        r_tail_l <= w_pop_last;
                    end
                    r_skid_cnt <= r_skid_cnt + 2'd1;
                end
                2'b01: begin
                    r_head_d   <= r_tail_d;
                    r_head_l   <= r_tail_l;
                    r_skid_cnt <= r_skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_skid_cnt == 2'd1) begin
                        r_head_d <= fifo_rdat;
                        r_head_l <= w_pop_last;
                    end else begin
                        r_head_d <= r_tail_d;
                        r_head_l <= r_tail_l;
                        r_tail_d <= fifo_rdat;
                        r_tail_l <= w_pop_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid = (r_skid_cnt != 2'd0);
    assign m_data  = r_head_d;
    assign m_last  = r_head_l && m_valid;

`ifdef SCFIFO_BURST_READER_STATS_EN
    logic        w_timeout_evt;
    logic [31:0] r_bursts, r_timeouts;

    // Only a release that the occupancy threshold would not have caused.
    assign w_timeout_evt = (r_state == S_COALESCE) && (fifo_used > C_ZERO) &&
                           (fifo_used < C_BMAX) && (r_timer == C_TMR_LAST);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_bursts   <= '0;
            r_timeouts <= '0;
        end else begin
            if (m_valid && m_ready && m_last) r_bursts <= r_bursts + 32'd1;
            if (w_timeout_evt) r_timeouts <= r_timeouts + 32'd1;
        end
    end

    assign o_bursts   = r_bursts;
    assign o_timeouts = r_timeouts;
`else
    assign o_bursts   = '0;
    assign o_timeouts = '0;
`endif

endmodule

// File: tb/tb_scfifo_burst_reader.sv
// Self-checking bench for scfifo_burst_reader. A queue models the show-ahead
// FIFO; expected burst framing is derived from the burst-size rules.
module tb_scfifo_burst_reader;

    localparam int DW   = 8;
    localparam int AW   = 6;
    localparam int BMAX = 16;
    localparam int TMO  = 32;
`ifdef SCFIFO_BURST_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 srst = 1'b1;
    logic                 fifo_rval = 1'b0;
    logic [DW-1:0]        fifo_rdat = '0;
    logic signed [AW:0]   fifo_used = '0;
    logic                 fifo_rden;
    logic                 m_valid;
    logic [DW-1:0]        m_data;
    logic                 m_last;
    logic                 m_ready = 1'b0;
    logic [31:0]          o_bursts;
    logic [31:0]          o_timeouts;

    always #5 clk = ~clk;

    scfifo_burst_reader #(
        .DATA_BITS(DW),
        .ADDR_BITS(AW),
        .BURST_MAX(BMAX),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .srst(srst),
        .fifo_rval(fifo_rval), .fifo_rdat(fifo_rdat), .fifo_used(fifo_used),
        .fifo_rden(fifo_rden),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .o_bursts(o_bursts), .o_timeouts(o_timeouts)
    );

    logic [DW-1:0] fq[$];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            got_c[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];

    logic    pop_now = 1'b0;
    bit      rst_req = 1'b1;
    bit      flush_req = 1'b0;
    int      rmode = 0;
    int      pat_i = 0;
    int      cyc = 0;
    int      pops = 0;
    int      first_pop = -1;
    int      last_pop = -1;
    logic    hold_pend = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic    hold_l = 1'b0;
    int      stall_viol = 0;
    int      rden_viol = 0;
    int      m_bursts = 0;
    int      m_timeouts = 0;
    int      n_checks = 0;
    int      n_pass = 0;

    // One clock: update FIFO model and drivers just after the edge, sample at negedge.
    task automatic step();
        logic [DW-1:0] tmp;
        @(posedge clk);
        #1;
        srst = rst_req;
        if (pop_now === 1'b1) begin
            if (fq.size() > 0) tmp = fq.pop_front();
        end
        if (flush_req) fq.delete();
        while (wq.size() > 0) fq.push_back(wq.pop_front());
        fifo_rval = (fq.size() > 0);
        fifo_rdat = (fq.size() > 0) ? fq[0] : '0;
        fifo_used = (AW + 1)'(fq.size());
        case (rmode)
            0: m_ready = 1'b1;
            1: begin m_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        @(negedge clk);
        cyc++;
        pop_now = fifo_rden;
        if (fifo_rden === 1'b1) begin
            pops++;
            last_pop = cyc;
            if (first_pop < 0) first_pop = cyc;
            if (!fifo_rval) rden_viol++;
        end
        if (hold_pend === 1'b1) begin
            if (m_valid !== 1'b1 || m_data !== hold_d || m_last !== hold_l) stall_viol++;
        end
        hold_pend = m_valid && !m_ready && !srst;
        hold_d = m_data;
        hold_l = m_last;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            got_c.push_back(cyc);
        end
    endtask

    task automatic clear_obs();
        got_d.delete(); got_l.delete(); got_c.delete();
        exp_d.delete(); exp_l.delete();
        first_pop = -1; last_pop = -1; stall_viol = 0;
    endtask

    // Reference framing for a FIFO loaded with no further writes: bursts of
    // BMAX words, the remainder forms one final burst released by timeout.
    function automatic void model_bursts();
        int n = exp_d.size();
        exp_l.delete();
        for (int i = 0; i < n; i++) exp_l.push_back((i % BMAX == BMAX - 1) || (i == n - 1));
        m_bursts += (n + BMAX - 1) / BMAX;
        if (n % BMAX != 0) m_timeouts++;
    endfunction

    task automatic wait_beats(input int n, input int budget);
        int b = 0;
        while (got_d.size() < n && b < budget) begin step(); b++; end
        repeat (6) step();
    endtask

    task automatic count_quiet(output int zeros);
        zeros = 0;
        while (pop_now !== 1'b1 && zeros < 300) begin zeros++; step(); end
    endtask

    task automatic test_reset();
        rst_req = 1'b1; rmode = 0;
        repeat (3) step();
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b exp 0", m_valid); else n_pass++;
        n_checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last: got %b exp 0", m_last); else n_pass++;
        n_checks++; if (m_data !== '0) $display("FAIL reset_m_data: got %0h exp 0", m_data); else n_pass++;
        n_checks++; if (fifo_rden !== 1'b0) $display("FAIL reset_rden: got %b exp 0", fifo_rden); else n_pass++;
        n_checks++; if (o_bursts !== 32'd0) $display("FAIL reset_bursts: got %0d exp 0", o_bursts); else n_pass++;
        n_checks++; if (o_timeouts !== 32'd0) $display("FAIL reset_timeouts: got %0d exp 0", o_timeouts); else n_pass++;
        rst_req = 1'b0;
        step();
    endtask

    task automatic test_full_burst();
        int p0;
        clear_obs(); rmode = 0; p0 = pops;
        for (int i = 0; i < BMAX; i++) begin
            wq.push_back(DW'(i)); exp_d.push_back(DW'(i)); step();
        end
        model_bursts();
        wait_beats(BMAX, 300);
        n_checks++; if (got_d.size() != BMAX) $display("FAIL full_count: got %0d exp %0d", got_d.size(), BMAX); else n_pass++;
        for (int i = 0; i < got_d.size() && i < BMAX; i++) begin
            n_checks++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]})
                $display("FAIL full_beat%0d: got last=%b data=%0h exp last=%b data=%0h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            else n_pass++;
        end
        n_checks++; if (pops - p0 != BMAX || last_pop - first_pop != BMAX - 1)
            $display("FAIL full_rden_run: got %0d pops over %0d cycles exp %0d contiguous", pops - p0, last_pop - first_pop + 1, BMAX);
        else n_pass++;
        n_checks++; if (got_c.size() == BMAX && got_c[BMAX-1] - got_c[0] != BMAX - 1)
            $display("FAIL full_consecutive: got span %0d exp %0d", got_c[BMAX-1] - got_c[0], BMAX - 1);
        else n_pass++;
        n_checks++; if (o_bursts !== (STATS ? 32'(m_bursts) : 32'd0)) $display("FAIL full_bursts: got %0d exp %0d", o_bursts, STATS ? m_bursts : 0); else n_pass++;
    endtask

    task automatic test_timeout();
        int zeros;
        logic [DW-1:0] v;
        clear_obs(); rmode = 0;
        for (int i = 0; i < 3; i++) begin
            v = DW'($urandom); wq.push_back(v); exp_d.push_back(v);
        end
        step();
        count_quiet(zeros);
        model_bursts();
        wait_beats(3, 100);
        // One IDLE cycle then TIMEOUT cycles of coalescing before the first pop.
        n_checks++; if (zeros != TMO + 1) $display("FAIL timeout_delay: got %0d quiet cycles exp %0d", zeros, TMO + 1); else n_pass++;
        n_checks++; if (got_d.size() != 3) $display("FAIL timeout_count: got %0d exp 3", got_d.size()); else n_pass++;
        for (int i = 0; i < got_d.size() && i < 3; i++) begin
            n_checks++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]})
                $display("FAIL timeout_beat%0d: got last=%b data=%0h exp last=%b data=%0h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            else n_pass++;
        end
        n_checks++; if (o_timeouts !== (STATS ? 32'(m_timeouts) : 32'd0)) $display("FAIL timeout_stat: got %0d exp %0d", o_timeouts, STATS ? m_timeouts : 0); else n_pass++;
        n_checks++; if (o_bursts !== (STATS ? 32'(m_bursts) : 32'd0)) $display("FAIL timeout_bursts: got %0d exp %0d", o_bursts, STATS ? m_bursts : 0); else n_pass++;
    endtask

    // Preloads n words, streams them with the given ready mode, checks framing.
    task automatic test_preloaded(input string tag, input int n, input int mode);
        logic [DW-1:0] v;
        clear_obs(); rmode = mode; pat_i = 0;
        for (int i = 0; i < n; i++) begin
            v = DW'($urandom); wq.push_back(v); exp_d.push_back(v);
        end
        model_bursts();
        step();
        wait_beats(n, 3000);
        n_checks++; if (got_d.size() != n) $display("FAIL %s_count: got %0d exp %0d", tag, got_d.size(), n); else n_pass++;
        for (int i = 0; i < got_d.size() && i < n; i++) begin
            n_checks++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]})
                $display("FAIL %s_beat%0d: got last=%b data=%0h exp last=%b data=%0h", tag, i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            else n_pass++;
        end
        n_checks++; if (stall_viol != 0) $display("FAIL %s_hold: got %0d unstable stalls exp 0", tag, stall_viol); else n_pass++;
        n_checks++; if (o_bursts !== (STATS ? 32'(m_bursts) : 32'd0)) $display("FAIL %s_bursts: got %0d exp %0d", tag, o_bursts, STATS ? m_bursts : 0); else n_pass++;
        n_checks++; if (o_timeouts !== (STATS ? 32'(m_timeouts) : 32'd0)) $display("FAIL %s_timeouts: got %0d exp %0d", tag, o_timeouts, STATS ? m_timeouts : 0); else n_pass++;
    endtask

    task automatic test_write_on_last_pop();
        int zeros, dummy;
        logic [DW-1:0] x, y;
        clear_obs(); rmode = 0;
        x = DW'($urandom); y = DW'($urandom);
        wq.push_back(x); exp_d.push_back(x);
        step();
        count_quiet(dummy);
        // The pop of x (occupancy 1) and the write of y land on the same edge.
        wq.push_back(y); exp_d.push_back(y);
        step();
        count_quiet(zeros);
        exp_l.delete(); exp_l.push_back(1'b1); exp_l.push_back(1'b1);
        m_bursts += 2; m_timeouts += 2;
        wait_beats(2, 100);
        n_checks++; if (zeros != TMO + 1) $display("FAIL wlp_delay: got %0d quiet cycles exp %0d", zeros, TMO + 1); else n_pass++;
        n_checks++; if (got_d.size() != 2) $display("FAIL wlp_count: got %0d exp 2", got_d.size()); else n_pass++;
        for (int i = 0; i < got_d.size() && i < 2; i++) begin
            n_checks++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]})
                $display("FAIL wlp_beat%0d: got last=%b data=%0h exp last=%b data=%0h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            else n_pass++;
        end
        n_checks++; if (o_timeouts !== (STATS ? 32'(m_timeouts) : 32'd0)) $display("FAIL wlp_timeouts: got %0d exp %0d", o_timeouts, STATS ? m_timeouts : 0); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int b, p0;
        clear_obs(); rmode = 0;
        for (int i = 0; i < BMAX; i++) wq.push_back(DW'($urandom));
        b = 0;
        while (got_d.size() < 5 && b < 200) begin step(); b++; end
        n_checks++; if (got_d.size() != 5) $display("FAIL rst_mid_progress: got %0d beats exp 5", got_d.size()); else n_pass++;
        rst_req = 1'b1;
        step();
        n_checks++; if (fifo_rden !== 1'b0) $display("FAIL rst_mid_rden: got %b exp 0", fifo_rden); else n_pass++;
        rst_req = 1'b0; flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        m_bursts = 0; m_timeouts = 0;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b exp 0", m_valid); else n_pass++;
        n_checks++; if (m_last !== 1'b0) $display("FAIL rst_mid_last: got %b exp 0", m_last); else n_pass++;
        n_checks++; if (o_bursts !== 32'd0 || o_timeouts !== 32'd0) $display("FAIL rst_mid_stats: got %0d/%0d exp 0/0", o_bursts, o_timeouts); else n_pass++;
        got_d.delete(); got_l.delete(); got_c.delete();
        p0 = pops;
        repeat (40) step();
        n_checks++; if (got_d.size() != 0 || pops != p0) $display("FAIL rst_mid_quiet: got %0d beats %0d pops exp 0 0", got_d.size(), pops - p0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_timeout();
        test_preloaded("backpressure", 20, 1);
        test_preloaded("split", 40, 0);
        test_write_on_last_pop();
        for (int r = 0; r < 4; r++) test_preloaded("random", $urandom_range(1, 60), 2);
        test_reset_mid_burst();
        n_checks++; if (rden_viol != 0) $display("FAIL rden_without_rval: got %0d exp 0", rden_viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
